// File: rtl/program_loader_if.sv
// Boot byte stream (host -> loader) and instruction-memory write port (loader -> imem).
// The loader takes the slave modport; the host/testbench side takes master.
interface program_loader_if #(
    parameter int ADDR_W = 32
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: byte stream (16-bit count, LE words, 8-bit sum) -> sequential imem writes from 0.
// A write lands the cycle after a word's last byte; byte_ready is decoded from state only.
module program_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    program_loader_if.slave bus,
    output logic            cpu_run,
    output logic            load_done,
    output logic            load_error
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [1:0]  lane;
    logic [23:0] word_buf;
    logic [7:0]  acc;
    logic [15:0] hdr_count;
    logic        accept;
    logic        last_word;
    logic        relaunch;

    assign accept    = bus.byte_valid && bus.byte_ready;
    assign hdr_count = {bus.byte_data, count[7:0]};
    assign last_word = (word_idx + 16'd1) == count;
    assign relaunch  = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_HDR0;
            S_HDR0:  if (accept) state_nxt = S_HDR1;
            S_HDR1: begin
                if (accept) begin
                    if ({1'b0, hdr_count} > DEPTH_LIM) begin
                        state_nxt = S_ERROR;
                    end else if (hdr_count == 16'd0) begin
                        state_nxt = S_CSUM;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            // The final word's write cycle overlaps CSUM, so the checksum byte needs no bubble.
            S_DATA:  if (accept && lane == 2'd3 && last_word) state_nxt = S_CSUM;
            S_CSUM:  if (accept) state_nxt = (bus.byte_data == acc) ? S_DONE : S_ERROR;
            S_DONE:  if (start) state_nxt = S_HDR0;
            S_ERROR: if (start) state_nxt = S_HDR0;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.byte_ready = (state == S_HDR0) || (state == S_HDR1) ||
                         (state == S_DATA) || (state == S_CSUM);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count        <= '0;
            word_idx     <= '0;
            lane         <= '0;
            word_buf     <= '0;
            acc          <= '0;
            bus.im_we    <= 1'b0;
            bus.im_addr  <= '0;
            bus.im_wdata <= '0;
            cpu_run      <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            bus.im_we  <= 1'b0;
            cpu_run    <= (state == S_DONE) && !start;
            load_done  <= (state == S_DONE) && !start;
            load_error <= (state == S_ERROR) && !start;
            if (relaunch) begin
                word_idx <= '0;
                acc      <= '0;
                lane     <= '0;
            end
            if (accept) begin
                case (state)
                    S_HDR0: count[7:0]  <= bus.byte_data;
                    S_HDR1: count[15:8] <= bus.byte_data;
                    S_DATA: begin
                        acc  <= acc + bus.byte_data;
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: word_buf[7:0]   <= bus.byte_data;
                            2'd1: word_buf[15:8]  <= bus.byte_data;
                            2'd2: word_buf[23:16] <= bus.byte_data;
                            default: begin
                                bus.im_we    <= 1'b1;
                                bus.im_wdata <= {bus.byte_data, word_buf};
                                bus.im_addr  <= ADDR_W'({word_idx, 2'b00});
                                word_idx     <= word_idx + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Random + directed boot images against a byte-index reference model; outputs compared every cycle.
module tb_program_loader;
    localparam int DEPTH = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_run;
    logic load_done;
    logic load_error;

    program_loader_if #(.ADDR_W(32)) bus ();

    program_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    bit rnd_start = 1'b0;
    int cyc = 0;
    logic [7:0] img[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position of each accepted byte in the image decides its meaning.
    bit          m_active  = 1'b0;
    int          m_k       = 0;
    int          m_cnt     = 0;
    int          m_outcome = 0;   // 0 none, 1 done, 2 error
    logic [7:0]  m_sum     = 8'h00;
    logic [31:0] m_word    = 32'h0;
    bit          e_we      = 1'b0;
    logic [31:0] e_addr    = 32'h0;
    logic [31:0] e_wdata   = 32'h0;
    bit          e_run     = 1'b0;
    bit          e_done    = 1'b0;
    bit          e_err     = 1'b0;

    always @(posedge clk) begin
        logic [7:0] b;
        int j;
        cyc++;
        e_we = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0; m_k = 0; m_cnt = 0; m_outcome = 0; m_sum = 8'h00;
            e_run = 1'b0; e_done = 1'b0; e_err = 1'b0;
        end else begin
            e_run  = (m_outcome == 1) && !start;
            e_done = e_run;
            e_err  = (m_outcome == 2) && !start;
            if (!m_active && start) begin
                m_active = 1'b1; m_k = 0; m_sum = 8'h00; m_outcome = 0;
            end else if (m_active && bus.byte_valid) begin
                b = bus.byte_data;
                if (m_k == 0) begin
                    m_cnt = int'(b);
                end else if (m_k == 1) begin
                    m_cnt = m_cnt + int'(b) * 256;
                    if (m_cnt > DEPTH) begin
                        m_active = 1'b0; m_outcome = 2;
                    end
                end else if (m_k < 2 + 4 * m_cnt) begin
                    j = m_k - 2;
                    m_sum = m_sum + b;
                    m_word[8*(j%4) +: 8] = b;
                    if (j % 4 == 3) begin
                        e_we = 1'b1;
                        e_addr = 32'((j / 4) * 4);
                        e_wdata = m_word;
                    end
                end else begin
                    m_active = 1'b0;
                    m_outcome = (b == m_sum) ? 1 : 2;
                end
                m_k++;
            end
        end
    end

    int          dut_nw = 0;
    logic [31:0] dut_addr = 32'h0;
    logic [31:0] dut_wdata = 32'h0;

    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            dut_nw++;
            dut_addr  = bus.im_addr;
            dut_wdata = bus.im_wdata;
        end
        if (chk_en) begin
            chk1("byte_ready", bus.byte_ready, m_active);
            chk1("im_we", bus.im_we, e_we);
            if (e_we) begin
                chk("im_addr", bus.im_addr, e_addr);
                chk("im_wdata", bus.im_wdata, e_wdata);
            end
            chk1("cpu_run", cpu_run, e_run);
            chk1("load_done", load_done, e_done);
            chk1("load_error", load_error, e_err);
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            bus.byte_valid = 1'b0;
            bus.byte_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        if (rnd_start && $urandom_range(0, 7) == 0) start = 1'b1;
        n = 0;
        while (bus.byte_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk1("send_timeout", bus.byte_ready, 1'b1);
        @(negedge clk);
        start = 1'b0;
        bus.byte_valid = 1'b0;
    endtask

    task automatic build(input int cnt, input bit bad, input bit fixed);
        logic [7:0]  s;
        logic [7:0]  b;
        logic [15:0] c16;
        c16 = 16'(cnt);
        img.delete();
        img.push_back(c16[7:0]);
        img.push_back(c16[15:8]);
        if (cnt > DEPTH) return;
        s = 8'h00;
        for (int i = 0; i < 4 * cnt; i++) begin
            b = fixed ? 8'(i + 1) : 8'($urandom);
            img.push_back(b);
            s = s + b;
        end
        img.push_back(bad ? (s ^ 8'h5A) : s);
    endtask

    task automatic send_img(input int maxgap);
        for (int i = 0; i < img.size(); i++) begin
            if (!m_active) break;
            send(img[i], (maxgap == 0) ? 0 : $urandom_range(0, maxgap));
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw0;
        int t0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk1("rst_byte_ready", bus.byte_ready, 1'b0);
        chk1("rst_im_we", bus.im_we, 1'b0);
        chk("rst_im_addr", bus.im_addr, 32'h0);
        chk("rst_im_wdata", bus.im_wdata, 32'h0);
        chk1("rst_cpu_run", cpu_run, 1'b0);
        chk1("rst_load_done", load_done, 1'b0);
        chk1("rst_load_error", load_error, 1'b0);

        // Single-word image: li a0,10
        nw0 = dut_nw;
        do_start();
        img = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB8};
        send_img(0);
        settle();
        chk("t1_writes", 32'(dut_nw - nw0), 32'd1);
        chk("t1_addr", dut_addr, 32'h0);
        chk("t1_wdata", dut_wdata, 32'h00A00513);
        chk1("t1_done", load_done, 1'b1);
        chk1("t1_run", cpu_run, 1'b1);
        chk1("t1_err", load_error, 1'b0);

        // Restart from DONE, then three words back-to-back
        nw0 = dut_nw;
        do_start();
        chk1("t2_run_drop", cpu_run, 1'b0);
        chk1("t2_done_drop", load_done, 1'b0);
        chk1("t2_ready", bus.byte_ready, 1'b1);
        build(3, 1'b0, 1'b1);
        send(img[0], 0);
        send(img[1], 0);
        t0 = cyc;
        for (int i = 2; i < 14; i++) send(img[i], 0);
        chk("t2_no_stall", 32'(cyc - t0), 32'd12);
        send(img[14], 0);
        settle();
        chk("t2_csum_byte", 32'(img[14]), 32'h0000004E);
        chk("t2_writes", 32'(dut_nw - nw0), 32'd3);
        chk("t2_last_addr", dut_addr, 32'h8);
        chk("t2_last_wdata", dut_wdata, 32'h0C0B0A09);
        chk1("t2_done", load_done, 1'b1);

        // Count one past capacity
        nw0 = dut_nw;
        do_start();
        build(DEPTH + 1, 1'b0, 1'b0);
        send_img(0);
        settle();
        chk1("t3_err", load_error, 1'b1);
        chk1("t3_ready", bus.byte_ready, 1'b0);
        chk("t3_writes", 32'(dut_nw - nw0), 32'd0);

        // Bad checksum
        nw0 = dut_nw;
        do_start();
        img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        send_img(0);
        settle();
        chk("t4_writes", 32'(dut_nw - nw0), 32'd1);
        chk("t4_wdata", dut_wdata, 32'h44332211);
        chk1("t4_err", load_error, 1'b1);
        chk1("t4_run", cpu_run, 1'b0);

        // Gap inside a word, then reset during the second word
        nw0 = dut_nw;
        do_start();
        send(8'h02, 0); send(8'h00, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 5); send(8'h44, 0);
        send(8'h55, 0);
        chk("t5_writes", 32'(dut_nw - nw0), 32'd1);
        chk("t5_wdata", dut_wdata, 32'h44332211);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk1("t5_rst_ready", bus.byte_ready, 1'b0);
        chk1("t5_rst_we", bus.im_we, 1'b0);
        chk("t5_rst_addr", bus.im_addr, 32'h0);
        chk("t5_rst_wdata", bus.im_wdata, 32'h0);
        chk1("t5_rst_run", cpu_run, 1'b0);
        chk1("t5_rst_done", load_done, 1'b0);
        chk1("t5_rst_err", load_error, 1'b0);
        do_start();
        build(2, 1'b0, 1'b0);
        send_img(2);
        settle();
        chk1("t5_done", load_done, 1'b1);

        // Randomized sessions; the first one fills memory exactly
        for (int it = 0; it < 40; it++) begin
            int c;
            c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH + 1, 65535))
                                            : int'($urandom_range(0, 6));
            if (it == 0) c = DEPTH;
            do_start();
            build(c, ($urandom_range(0, 4) == 0), 1'b0);
            rnd_start = 1'b1;
            if (it != 0 && $urandom_range(0, 7) == 0) begin
                for (int i = 0; i < img.size() / 2; i++) send(img[i], $urandom_range(0, 2));
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                send_img(3);
            end
            rnd_start = 1'b0;
            settle();
            repeat ($urandom_range(0, 3)) begin
                bus.byte_valid = 1'b1;
                bus.byte_data  = 8'($urandom);
                @(negedge clk);
            end
            bus.byte_valid = 1'b0;
        end

        settle();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage directly upstream of the single-cycle processor's instruction memory.
- Accepts a byte stream (host/UART side) carrying a word count, program words and a checksum.
- Assembles little-endian 32-bit words and writes them sequentially into instruction memory from address 0.
- Holds the processor stalled (cpu_run low) until a complete, checksum-valid image is loaded.

Parameters:
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words; valid range 1..65535.
- ADDR_W, 32, width of im_addr (byte address, matches pc_out width).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  single-cycle pulse that begins a load session
- byte_valid  input  1  upstream byte available
- byte_data  input  8  upstream byte
- byte_ready  output  1  loader accepts byte this cycle
- im_we  output  1  instruction memory write strobe
- im_addr  output  ADDR_W  write byte address, always word-aligned
- im_wdata  output  32  write data
- cpu_run  output  1  high = processor may fetch/execute; low = processor PC held
- load_done  output  1  image loaded and verified
- load_error  output  1  size overflow or checksum mismatch

Behaviour:
- Transfer occurs on any rising clk edge with byte_valid && byte_ready.
- Reset: one clock with rst_n=0 clears everything. State=IDLE; byte_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_run=0, load_done=0, load_error=0; all counters and the checksum accumulator are 0.
- Reset mid-load aborts the session. Already-written instruction memory words are not erased.
- States:
  - IDLE: byte_ready=0. start -> HDR0.
  - HDR0: byte_ready=1. Byte = count[7:0] -> HDR1.
  - HDR1: byte_ready=1. Byte = count[15:8].
    - If count > DEPTH_WORDS -> ERROR.
    - Else if count == 0 -> CSUM.
    - Else -> DATA.
  - DATA: byte_ready=1.
    - Bytes are accepted in order b0..b3 and form word = {b3,b2,b1,b0}.
    - Each data byte is added mod 256 to the checksum accumulator. Header bytes are not summed.
    - On acceptance of b3: the next cycle im_we=1 for exactly one cycle, im_wdata=word, im_addr=word_idx*4. word_idx then increments.
    - byte_ready stays 1 during the write cycle, so back-to-back bytes are accepted without a bubble.
    - After the write of word count-1 -> CSUM.
  - CSUM: byte_ready=1. Received byte == accumulator -> DONE, else -> ERROR.
  - DONE: byte_ready=0, load_done=1, cpu_run=1 (registered, asserted the cycle after entering DONE).
  - ERROR: byte_ready=0, load_error=1, cpu_run=0.
- start:
  - Ignored in HDR0/HDR1/DATA/CSUM.
  - In DONE or ERROR it clears load_done/load_error/cpu_run, word_idx and the accumulator, then enters HDR0 on the next cycle.
- byte_valid low in any receiving state: hold state; no partial-word change.
- Byte lane index: 2-bit counter, wraps 3 -> 0 on each completed word.
- im_addr wrap: not possible, since count ≤ DEPTH_WORDS is enforced in HDR1.
- Outputs are registered except byte_ready, which is decoded from state.

Test Plan:
- Reset then start, stream 01 00 13 05 A0 00 B8 -> one im_we pulse with im_addr=0x0, im_wdata=0x00A00513; then load_done=1, cpu_run=1, load_error=0.
- start, count=3 (03 00), 12 data bytes streamed back-to-back with byte_valid held high, correct checksum -> im_we pulses at addr 0x0, 0x4, 0x8 with little-endian words; no stalled cycles; DONE.
- start, count=0x0101 with DEPTH_WORDS=256 -> ERROR after 2nd header byte; load_error=1, byte_ready=0, no im_we.
- start, count=1, bytes 11 22 33 44, checksum 0x00 (correct is 0xAA) -> im_we once with 0x44332211; then load_error=1, cpu_run=0.
- Mid-DATA gaps (byte_valid=0 for 5 cycles between b1 and b2) -> word still 0x44332211, single write. Then rst_n=0 during the second word -> all outputs 0, state IDLE; later start + valid image -> DONE.
- From DONE, pulse start -> cpu_run falls next cycle, load_done=0, loader in HDR0; a new image reloads from address 0x0.
